// File: rtl/serial_twos_complementer.sv
// Bit-serial two's complementer: negates a WIDTH-bit operand one bit per
// cycle, LSB first, using the "copy up to the first 1, then invert" rule.
module serial_twos_complementer #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             serial_out
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             seen_q, seen_d;
    logic             ser_q, ser_d;
    logic             done_q, done_d;
    logic             bit_r;

    // Next-state logic: capture on start, then one result bit per cycle.
    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        ser_d   = ser_q;
        done_d  = 1'b0;
        bit_r   = opnd_q[0] ^ seen_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    opnd_d  = din;
                    cnt_d   = '0;
                    seen_d  = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                seen_d = seen_q | opnd_q[0];
                opnd_d = opnd_q >> 1;
                res_d  = {bit_r, res_q[WIDTH-1:1]};
                ser_d  = bit_r;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State registers; reset aborts any conversion and clears the result.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            ser_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
        end
    end

    assign busy       = (state_q == SHIFT);
    assign done       = done_q;
    assign dout       = res_q;
    assign serial_out = ser_q;

endmodule

// File: tb/tb_serial_twos_complementer.sv
// Scoreboard bench for serial_twos_complementer: an arithmetic negation
// model feeds a queue that a negedge monitor drains on every done pulse.
module tb_serial_twos_complementer;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] din = '0;
    logic         busy, done, serial_out;
    logic [W-1:0] dout;

    int checks = 0;
    int errors = 0;
    int acc = 0;
    int done_cnt = 0;
    int model_cnt = 0;
    bit exp_done = 1'b0;
    logic [W-1:0] sb[$];

    logic [W-1:0] col = '0;
    logic [W-1:0] last_dout = '0;
    bit           prev_busy = 1'b0;

    serial_twos_complementer #(.WIDTH(W)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .start(start),
        .din(din),
        .busy(busy),
        .done(done),
        .dout(dout),
        .serial_out(serial_out)
    );

    always #5 Clk = ~Clk;

    task automatic chk(string n, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] neg(logic [W-1:0] d);
        longint m;
        m = longint'(1) << W;
        return W'((m - longint'(d)) % m);
    endfunction

    // Reference: a conversion occupies W cycles after acceptance; a new
    // start is taken only when no conversion is outstanding.
    always @(posedge Clk) begin
        if (!Reset) begin
            exp_done = (model_cnt == 1);
            if (model_cnt != 0) begin
                model_cnt = model_cnt - 1;
            end else if (start) begin
                sb.push_back(neg(din));
                model_cnt = W;
                acc++;
            end
        end
    end

    always @(posedge Reset) begin
        if (model_cnt != 0) acc--;
        model_cnt = 0;
        exp_done = 1'b0;
        sb.delete();
    end

    // Monitor: protocol checks every cycle, result checks on done.
    always @(negedge Clk) begin
        if (Reset) begin
            prev_busy = 1'b0;
            col = '0;
            last_dout = '0;
        end else begin
            chk("busy", 32'(busy), 32'(model_cnt != 0));
            chk("done", 32'(done), 32'(exp_done));
            if ((busy && prev_busy) || done)
                col = {serial_out, col[W-1:1]};
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("done_without_start", 32'(1), 32'(0));
                end else begin
                    logic [W-1:0] e;
                    e = sb.pop_front();
                    chk("dout", 32'(dout), 32'(e));
                    chk("serial_seq", 32'(col), 32'(e));
                end
                last_dout = dout;
            end else if (!busy || !prev_busy) begin
                chk("dout_hold", 32'(dout), 32'(last_dout));
            end
            prev_busy = busy;
        end
    end

    task automatic step(logic s, logic [W-1:0] d);
        @(negedge Clk);
        start = s;
        din = d;
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, W'($urandom));
    endtask

    task automatic conv(logic [W-1:0] d);
        step(1'b1, d);
        idle(W + 1);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_dout"}, 32'(dout), 32'(0));
        chk({tag, "_serial"}, 32'(serial_out), 32'(0));
    endtask

    initial begin
        int target;
        int guard;
        repeat (2) @(negedge Clk);
        chk_zero("reset");
        Reset = 1'b0;
        idle(2);

        conv(8'h06);
        conv(8'h00);
        conv(8'h80);
        conv(8'h01);
        conv(8'hFF);

        step(1'b1, 8'h12);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        step(1'b1, 8'h34);
        step(1'b1, 8'h34);
        step(1'b0, 8'h34);
        idle(W);

        step(1'b1, W'($urandom));
        repeat (4) @(negedge Clk);
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1 chk_zero("async_reset");
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        start = 1'b1;
        din = 8'h03;
        idle(W + 1);

        step(1'b1, 8'h05);
        repeat (5 * (W + 1) - 1) step(1'b1, 8'h05);
        idle(W + 2);

        target = acc + 1000;
        guard = 0;
        while (acc < target && guard < 30000) begin
            step(($urandom % 4) != 0, W'($urandom));
            guard++;
        end
        if (acc < target) chk("random_timeout", 32'(acc), 32'(target));
        idle(W + 2);

        chk("queue_empty", 32'(sb.size()), 32'(0));
        chk("done_count", 32'(done_cnt), 32'(acc));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
